// File: rtl/sequenciador_circuito.sv
// -----------------------------------------------------------------------------
// sequenciador_circuito
//
// Registered test-vector sequencer for a 4-input / 3-output combinational
// circuit. On start it walks an inclusive range of 4-bit vectors {A,B,C,D}
// (wrapping through 4'hF -> 4'h0 when first_vec > last_vec). Each vector is
// held for SETTLE_CYCLES edges, the circuit's Saida is captured, and the pair
// {vector, Saida} is offered on a valid/ready result port.
//
// Parameters:
//   SETTLE_CYCLES : edges each vector is held before Saida is sampled (1..15)
//   CNT_W         : settle counter width, 2**CNT_W > SETTLE_CYCLES
//
// Ports:
//   clk        in   clock, all state updates on rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin a run (sampled only in IDLE)
//   first_vec  in   [3:0] first vector {A,B,C,D}, MSB = A (sampled with start)
//   last_vec   in   [3:0] last vector, inclusive (sampled with start)
//   A,B,C,D    out  registered drive to the circuit under test
//   saida_in   in   [2:0] Saida returned from the circuit
//   res_valid  out  result available
//   res_ready  in   consumer accepts result
//   res_vec    out  [3:0] vector that produced res_saida
//   res_saida  out  [2:0] captured Saida
//   busy       out  high from start-accept edge until the run ends
//   done       out  one-cycle pulse on the final handshake
//   sig_out    out  [7:0] rotate-xor signature of captured Saida values
//                   (present only when SEQ_SIGNATURE_EN is defined)
//
// Optional feature macro: SEQ_SIGNATURE_EN
// -----------------------------------------------------------------------------
module sequenciador_circuito #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] first_vec,
    input  logic [3:0] last_vec,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    input  logic [2:0] saida_in,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_vec,
    output logic [2:0] res_saida,
    output logic       busy,
    output logic       done
`ifdef SEQ_SIGNATURE_EN
    ,
    output logic [7:0] sig_out
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    // Counter value on the edge where Saida is captured. Counting starts at 0
    // on the edge the vector changes, so the capture lands exactly
    // SETTLE_CYCLES edges after the new vector appeared on A..D.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       vec_q;
    logic [3:0]       end_q;
    logic [CNT_W-1:0] cnt_q;
    logic             res_valid_q;
    logic [3:0]       res_vec_q;
    logic [2:0]       res_saida_q;
    logic             busy_q;
    logic             done_q;

    // Next vector in the walk; 4-bit arithmetic gives the 4'hF -> 4'h0 wrap
    // needed for ranges with first_vec > last_vec.
    logic [3:0]       vec_next_d;
    logic             handshake_d;
    logic             last_d;

    assign vec_next_d  = vec_q + 4'd1;
    assign handshake_d = res_valid_q & res_ready;
    assign last_d      = (vec_q == end_q);

`ifdef SEQ_SIGNATURE_EN
    logic [7:0] sig_q;
    logic [7:0] sig_d;

    // Rotate left by one, then fold in the freshly captured Saida.
    assign sig_d   = {sig_q[6:0], sig_q[7]} ^ {5'b0, saida_in};
    assign sig_out = sig_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_q       <= 4'd0;
            end_q       <= 4'd0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_vec_q   <= 4'd0;
            res_saida_q <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_SIGNATURE_EN
            sig_q       <= 8'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        end_q   <= last_vec;
                        vec_q   <= first_vec;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_SETTLE;
`ifdef SEQ_SIGNATURE_EN
                        sig_q   <= 8'd0;
`endif
                    end
                end

                ST_SETTLE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        res_saida_q <= saida_in;
                        res_vec_q   <= vec_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
`ifdef SEQ_SIGNATURE_EN
                        sig_q       <= sig_d;
`endif
                    end
                end

                ST_OUT: begin
                    // Result is held untouched until accepted; no timeout.
                    if (handshake_d) begin
                        res_valid_q <= 1'b0;
                        if (last_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            vec_q   <= vec_next_d;
                            cnt_q   <= '0;
                            state_q <= ST_SETTLE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign A         = vec_q[3];
    assign B         = vec_q[2];
    assign C         = vec_q[1];
    assign D         = vec_q[0];
    assign res_valid = res_valid_q;
    assign res_vec   = res_vec_q;
    assign res_saida = res_saida_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sequenciador_circuito.sv
module tb_sequenciador_circuito;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] first_vec;
    logic [3:0] last_vec;
    logic       A, B, C, D;
    logic [2:0] saida_in;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_vec;
    logic [2:0] res_saida;
    logic       busy;
    logic       done;
`ifdef SEQ_SIGNATURE_EN
    logic [7:0] sig_out;
`endif

    always #5 clk = ~clk;

    // Circuit stub: Saida = popcount(A,B,C,D)
    assign saida_in = {2'b00, A} + {2'b00, B} + {2'b00, C} + {2'b00, D};

    sequenciador_circuito #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first_vec (first_vec),
        .last_vec  (last_vec),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .saida_in  (saida_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_vec   (res_vec),
        .res_saida (res_saida),
        .busy      (busy),
        .done      (done)
`ifdef SEQ_SIGNATURE_EN
        ,
        .sig_out   (sig_out)
`endif
    );

    int n_vec  = 0;
    int n_err  = 0;
    int done_cnt = 0;
    logic [6:0] sb[$];   // expected {vec, saida}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] pop4(input logic [3:0] v);
        return {2'b00, v[3]} + {2'b00, v[2]} + {2'b00, v[1]} + {2'b00, v[0]};
    endfunction

    // Scoreboard monitor: compares every accepted result.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {25'd0, res_vec, res_saida}, 32'hFFFF_FFFF);
            end else begin
                logic [6:0] e;
                e = sb.pop_front();
                chk("result", {25'd0, res_vec, res_saida}, {25'd0, e});
                chk("abcd_vs_res_vec", {28'd0, A, B, C, D}, {28'd0, res_vec});
            end
        end
        if (rst_n && done) begin
            done_cnt++;
            chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
    end

    task automatic launch(input logic [3:0] f, input logic [3:0] l);
        logic [3:0] v;
        v = f;
        forever begin
            sb.push_back({v, pop4(v)});
            if (v == l) break;
            v = v + 4'd1;
        end
        first_vec = f;
        last_vec  = l;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("abcd_after_start", {28'd0, A, B, C, D}, {28'd0, f});
    endtask

    task automatic wait_done();
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_seen_once", done_cnt - d0, 32'd1);
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!res_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!res_valid) chk(name, 32'd0, 32'd1);
    endtask

`ifdef SEQ_SIGNATURE_EN
    function automatic logic [7:0] sig_model(input logic [3:0] f, input logic [3:0] l);
        logic [7:0] s;
        logic [3:0] v;
        s = 8'd0;
        v = f;
        forever begin
            s = {s[6:0], s[7]} ^ {5'b0, pop4(v)};
            if (v == l) break;
            v = v + 4'd1;
        end
        return s;
    endfunction
`endif

    initial begin
        int lat;
        int d0;
        logic [3:0] hv;
        logic [2:0] hs;
        rst_n = 1'b0; start = 1'b0; first_vec = 4'd0; last_vec = 4'd0; res_ready = 1'b1;

        // 1. reset state, then full sweep
        repeat (2) @(posedge clk);
        #1;
        chk("rst_abcd", {28'd0, A, B, C, D}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_vec", {28'd0, res_vec}, 32'd0);
        chk("rst_res_saida", {29'd0, res_saida}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
`ifdef SEQ_SIGNATURE_EN
        chk("rst_sig", {24'd0, sig_out}, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        launch(4'd0, 4'd15);
        wait_done();

        // 2. single vector, latency to first valid
        launch(4'd5, 4'd5);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("first_valid_latency", lat, 32'd2);
        wait_done();

        // 3. wrapping range 14 -> 1
        launch(4'd14, 4'd1);
        wait_done();

        // 4. back-pressure: result and drive held while res_ready=0
        res_ready = 1'b0;
        launch(4'd3, 4'd4);
        wait_valid("stall_valid_timeout");
        hv = res_vec;
        hs = res_saida;
        chk("stall_first_vec", {28'd0, hv}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_vec", {28'd0, res_vec}, {28'd0, hv});
            chk("stall_saida", {29'd0, res_saida}, {29'd0, hs});
            chk("stall_abcd", {28'd0, A, B, C, D}, {28'd0, hv});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("resume_valid_low", {31'd0, res_valid}, 32'd0);
        chk("resume_abcd_next", {28'd0, A, B, C, D}, 32'd4);
        wait_done();

        // 5. reset mid-run at vector 7
        launch(4'd0, 4'd15);
        lat = 0;
        while (!(res_valid && res_vec == 4'd7) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("reach_vec7", {28'd0, res_vec}, 32'd7);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        chk("midrst_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done_pulse", done_cnt - d0, 32'd0);
        launch(4'd0, 4'd2);
        wait_done();

        // start pulse with new range while busy must be ignored
        launch(4'd0, 4'd2);
        first_vec = 4'd9; last_vec = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

`ifdef SEQ_SIGNATURE_EN
        // 6. signature over vectors 0..3
        launch(4'd0, 4'd3);
        wait_done();
        chk("signature", {24'd0, sig_out}, {24'd0, sig_model(4'd0, 4'd3)});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
